// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_instr_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between imem responses and decode.
module if_instr_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2 * XLEN,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, stale-response dropping on redirect.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise fetch_misaligned.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            fetch_misaligned,
`endif
    input  logic            instr_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_used;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   target_pc;
    logic              active;
    logic              halted;
    logic              req_fire;
    logic              drop_rsp;
    logic              push;
    logic              pop;

    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
    fetch_state_e state;
    fetch_state_e state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (redirect_pc[1:0] != 2'b00) ? FETCH_HALT : FETCH_RUN;
        end
    end

    assign halted           = (state == FETCH_HALT);
    assign fetch_misaligned = halted;
`else
    logic unused_low_bits;

    assign halted          = 1'b0;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

    // inflight includes requests already marked for dropping, so credits stay exact.
    assign credit_used    = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = active && !halted && !redirect_valid
                            && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign drop_rsp       = (drop_cnt != '0) || halted;
    assign push           = imem_rsp_valid && !drop_rsp && !redirect_valid;
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid    = (count != '0);
    assign {instr_pc, instr_out} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            active   <= 1'b0;
        end else begin
            active   <= 1'b1;
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + XLEN'(INSTR_BYTES);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    if_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with an in-order, variable-latency imem model.
module tb_if_fetch_unit;

    localparam int FIFO_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IF_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    bit          model_halt;
    int          cyc;
    int          lat_min;
    int          lat_max;
    bit          rand_ready;
    bit          instr_rand;
    int          consumed;
    int          n_checks;
    int          n_pass;
    int          mark;

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
`ifdef IF_MISALIGN_TRAP_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .instr_ready      (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_5A00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy, input int cycles);
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = instr_rand ? 1'($urandom_range(0, 1)) : rdy;
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            instr_ready    = instr_rand ? 1'($urandom_range(0, 1)) : rdy;
        end
    endtask

    // Instruction memory model plus the architectural PC model that feeds the scoreboard.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                exp_q.delete();
                model_pc       = 32'h0;
                model_halt     = 1'b0;
                imem_rsp_valid = 1'b0;
                imem_req_ready = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
                imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (redirect_valid) begin
                    checkOutput("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
                    exp_q.delete();
                    model_pc = {redirect_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
                    model_halt = (redirect_pc[1:0] != 2'b00);
`endif
                end else if (model_halt) begin
                    checkOutput("req_valid_while_halted", 32'(imem_req_valid), 32'd0);
                end else if (imem_req_valid && imem_req_ready) begin
                    checkOutput("req_addr", imem_req_addr, model_pc);
                    pend.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
                checkOutput("credit_bound",
                            32'(pend.size() <= FIFO_DEPTH && exp_q.size() <= FIFO_DEPTH), 32'd1);
            end
            cyc++;
        end
    end

    // Monitor: every instruction decode accepts must be the next expected PC and word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL spurious_instr: got pc %h, expected no instruction", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("instr_pc", instr_pc, e);
                    checkOutput("instr_out", instr_out, mem_word(e));
                end
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        consumed       = 0;
        cyc            = 0;
        lat_min        = 1;
        lat_max        = 1;
        rand_ready     = 1'b0;
        instr_rand     = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        repeat (3) @(negedge clk);
        #3;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr_out", instr_out, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] streaming from reset");
        applyStimulus(1'b0, '0, 1'b1, 30);
        checkOutput("stream_progress", 32'(consumed >= 10), 32'd1);

        $display("[TB] decode stalled");
        applyStimulus(1'b0, '0, 1'b0, 10);
        #3;
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_instr_valid", 32'(instr_valid), 32'd1);
        mark = consumed;
        applyStimulus(1'b0, '0, 1'b1, 20);
        checkOutput("stall_release_progress", 32'(consumed > mark + 5), 32'd1);

        $display("[TB] redirect with fetches in flight");
        lat_min = 3;
        lat_max = 3;
        applyStimulus(1'b0, '0, 1'b1, 9);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("redir_flush_valid", 32'(instr_valid), 32'd0);
        checkOutput("redir_req_addr", imem_req_addr, 32'h0000_0100);
        mark = consumed;
        applyStimulus(1'b0, '0, 1'b1, 30);
        checkOutput("redir_progress", 32'(consumed > mark), 32'd1);

        $display("[TB] redirect during response and pop, then back-to-back");
        lat_min = 1;
        lat_max = 1;
        applyStimulus(1'b0, '0, 1'b1, 7);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("redir2_flush_valid", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 6);
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1);
        applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("b2b_req_addr", imem_req_addr, 32'h0000_0500);
        applyStimulus(1'b0, '0, 1'b1, 20);

        $display("[TB] random ready and latency");
        rand_ready = 1'b1;
        lat_max    = 3;
        instr_rand = 1'b1;
        mark       = consumed;
        applyStimulus(1'b0, '0, 1'b1, 100);
        applyStimulus(1'b1, 32'h0000_1000, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 100);
        checkOutput("random_progress", 32'(consumed > mark + 10), 32'd1);
        rand_ready = 1'b0;
        instr_rand = 1'b0;
        lat_max    = 1;

`ifdef IF_MISALIGN_TRAP_EN
        $display("[TB] misaligned redirect trap");
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("trap_flag_set", 32'(fetch_misaligned), 32'd1);
        checkOutput("trap_req_valid", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 6);
        #3;
        checkOutput("trap_still_halted", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("trap_flag_clear", 32'(fetch_misaligned), 32'd0);
        checkOutput("trap_resume_addr", imem_req_addr, 32'h0000_0200);
`else
        $display("[TB] misaligned redirect alignment");
        applyStimulus(1'b1, 32'h0000_0106, 1'b1, 1);
        applyStimulus(1'b0, '0, 1'b1, 1);
        #3;
        checkOutput("align_req_addr", imem_req_addr, 32'h0000_0104);
`endif
        mark = consumed;
        applyStimulus(1'b0, '0, 1'b1, 20);
        checkOutput("final_progress", 32'(consumed > mark), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
